// File: rtl/ptf_frame_writer.sv
// Frame writer: bounds-checks transformed pixels, queues them in a FIFO and issues
// single-word writes to the memory arbiter with double-buffered banks. Optional: PTF_WRITER_CLEAR_EN.
module ptf_frame_writer #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int FIFO_AW = 4,
    parameter int ADDR_W  = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_flag,
    input  logic [17:0]       pixel_in,
    input  logic [9:0]        pixel_x,
    input  logic [8:0]        pixel_y,
    input  logic              pixel_in_flag,
    output logic              mem_req,
    output logic [ADDR_W:0]   mem_addr,
    output logic [17:0]       mem_data,
    input  logic              mem_ack,
    output logic              display_bank,
    output logic              drop_pulse,
    output logic              frame_overrun
);
    localparam int ENTRY_W = ADDR_W + 19;
    localparam int DEPTH   = 1 << FIFO_AW;
    localparam int CNT_W   = FIFO_AW + 3;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SWAP_PENDING = 1'b1} state_t;

    state_t              state_q;
    logic                write_bank_q;
    logic                display_bank_q;
    logic [CNT_W-1:0]    drain_q;
    logic                s1_valid_q;
    logic                s1_bank_q;
    logic [ADDR_W-1:0]   s1_addr_q;
    logic [17:0]         s1_pix_q;
    logic [ENTRY_W-1:0]  fifo_mem [DEPTH];
    logic [FIFO_AW:0]    wptr_q;
    logic [FIFO_AW:0]    rptr_q;
    logic                mem_req_q;
    logic [ADDR_W:0]     mem_addr_q;
    logic [17:0]         mem_data_q;
    logic                drop_q;
    logic                overrun_q;

    logic                in_bounds_s;
    logic [ADDR_W-1:0]   s1_addr_d;
    logic [FIFO_AW:0]    count_s;
    logic                empty_s;
    logic                full_s;
    logic                load_slot_s;
    logic                pop_s;
    logic                push_s;
    logic                drop_s;
    logic                mem_req_d;
    logic [CNT_W-1:0]    in_flight_s;
    logic [CNT_W-1:0]    old_dec_s;
    logic                swap_go_s;
    logic                swap_done_s;
    logic                clear_busy_s;
    logic                clr_load_s;

    assign in_bounds_s = pixel_in_flag && ({22'd0, pixel_x} < 32'(H_RES))
                                       && ({23'd0, pixel_y} < 32'(V_RES));
    assign s1_addr_d   = ADDR_W'(pixel_y) * ADDR_W'(H_RES) + ADDR_W'(pixel_x);
    assign count_s     = wptr_q - rptr_q;
    assign empty_s     = (wptr_q == rptr_q);
    assign full_s      = count_s[FIFO_AW];

    // Handshake, FIFO and bank-drain bookkeeping for the coming edge
    always_comb begin
        load_slot_s = !mem_req_q || mem_ack;
        pop_s       = !empty_s && load_slot_s && !clear_busy_s;
        push_s      = s1_valid_q && (!full_s || pop_s);
        drop_s      = s1_valid_q && full_s && !pop_s;
        mem_req_d   = pop_s || clr_load_s || (mem_req_q && !mem_ack);
        // Everything still in flight after this edge belongs to the outgoing bank
        in_flight_s = CNT_W'(count_s) + CNT_W'(push_s) - CNT_W'(pop_s)
                    + CNT_W'(mem_req_d) + CNT_W'(in_bounds_s);
        old_dec_s   = CNT_W'(mem_req_q && mem_ack && (mem_addr_q[ADDR_W] != write_bank_q))
                    + CNT_W'(drop_s && (s1_bank_q != write_bank_q));
        swap_go_s   = 1'b0;
        swap_done_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                swap_go_s   = frame_flag && !clear_busy_s;
                swap_done_s = swap_go_s && (in_flight_s == {CNT_W{1'b0}});
            end
            ST_SWAP_PENDING: begin
                swap_done_s = (drain_q <= old_dec_s);
            end
            default: begin
                swap_go_s   = 1'b0;
                swap_done_s = 1'b0;
            end
        endcase
    end

    // Bank FSM: toggle write bank, drain old entries, publish completed bank
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            write_bank_q   <= 1'b0;
            display_bank_q <= 1'b1;
            drain_q        <= {CNT_W{1'b0}};
            overrun_q      <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (swap_go_s) begin
                        write_bank_q <= ~write_bank_q;
                        if (swap_done_s) begin
                            display_bank_q <= write_bank_q;
                        end else begin
                            drain_q <= in_flight_s;
                            state_q <= ST_SWAP_PENDING;
                        end
                    end else if (frame_flag) begin
                        overrun_q <= 1'b1;
                    end
                end
                ST_SWAP_PENDING: begin
                    overrun_q <= frame_flag;
                    if (swap_done_s) begin
                        drain_q        <= {CNT_W{1'b0}};
                        display_bank_q <= ~write_bank_q;
                        state_q        <= ST_IDLE;
                    end else begin
                        drain_q <= drain_q - old_dec_s;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Stage 1: bounds-checked address, tagged with the bank current at the strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_bank_q  <= 1'b0;
            s1_addr_q  <= {ADDR_W{1'b0}};
            s1_pix_q   <= 18'd0;
        end else begin
            s1_valid_q <= in_bounds_s;
            if (in_bounds_s) begin
                s1_bank_q <= write_bank_q;
                s1_addr_q <= s1_addr_d;
                s1_pix_q  <= pixel_in;
            end
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem[wptr_q[FIFO_AW-1:0]] <= {s1_bank_q, s1_addr_q, s1_pix_q};
        end
    end

    // FIFO pointers, output request register and drop pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q     <= {(FIFO_AW+1){1'b0}};
            rptr_q     <= {(FIFO_AW+1){1'b0}};
            mem_req_q  <= 1'b0;
            mem_addr_q <= {(ADDR_W+1){1'b0}};
            mem_data_q <= 18'd0;
            drop_q     <= 1'b0;
        end else begin
            wptr_q    <= wptr_q + (FIFO_AW+1)'(push_s);
            rptr_q    <= rptr_q + (FIFO_AW+1)'(pop_s);
            mem_req_q <= mem_req_d;
            drop_q    <= drop_s;
            if (clr_load_s) begin
                mem_addr_q <= {write_bank_q, clear_addr_s()};
                mem_data_q <= 18'd0;
            end else if (pop_s) begin
                {mem_addr_q, mem_data_q} <= fifo_mem[rptr_q[FIFO_AW-1:0]];
            end
        end
    end

`ifdef PTF_WRITER_CLEAR_EN
    localparam logic [ADDR_W-1:0] CLEAR_LAST = ADDR_W'(H_RES * V_RES - 1);

    logic              clear_active_q;
    logic [ADDR_W-1:0] clear_cnt_q;

    assign clear_busy_s = clear_active_q;
    assign clr_load_s   = clear_active_q && load_slot_s;

    function automatic logic [ADDR_W-1:0] clear_addr_s();
        return clear_cnt_q;
    endfunction

    // Zero-fill sweep of the new write bank after every completed swap
    always_ff @(posedge clk) begin
        if (reset) begin
            clear_active_q <= 1'b0;
            clear_cnt_q    <= {ADDR_W{1'b0}};
        end else if (swap_done_s) begin
            clear_active_q <= 1'b1;
            clear_cnt_q    <= {ADDR_W{1'b0}};
        end else if (clr_load_s) begin
            if (clear_cnt_q == CLEAR_LAST) begin
                clear_active_q <= 1'b0;
            end
            clear_cnt_q <= clear_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end
`else
    assign clear_busy_s = 1'b0;
    assign clr_load_s   = 1'b0;

    function automatic logic [ADDR_W-1:0] clear_addr_s();
        return {ADDR_W{1'b0}};
    endfunction
`endif

    assign mem_req       = mem_req_q;
    assign mem_addr      = mem_addr_q;
    assign mem_data      = mem_data_q;
    assign display_bank  = display_bank_q;
    assign drop_pulse    = drop_q;
    assign frame_overrun = overrun_q;

endmodule
